rmii_frame_tx: RTL and testbench

Transmit-side framer for the 100 Mbit/s RMII PHY link. It accepts a frame length and a start pulse from the layer above, then reads payload bytes one at a time from an upstream byte FIFO. It wraps the payload with preamble, SFD, minimum-length padding and CRC-32 FCS, serialises everything as dibits on rmii_txen/rmii_txdata, and enforces the inter-frame gap. It forms the wire end of the txstart/txamount/txreq/txdata/txbusy handshake that the UDP layer drives.

---
 rtl/rmii_frame_tx.sv | 168 ++++++++++++++++
 tb/tb_rmii_frame_tx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rmii_frame_tx.sv
// RMII transmit framer: preamble, SFD, payload fetched from a registered-Q byte FIFO,
// zero padding to MIN_LEN, CRC-32 FCS, then the inter-frame gap.
module rmii_frame_tx #(
  parameter int MIN_LEN    = 60,
  parameter int MAX_LEN    = 1514,
  parameter int IFG_CYCLES = 48
) (
  input  logic        rmii_clk,
  input  logic        sys_rst,
  input  logic        tx_start,
  input  logic [15:0] tx_amount,
  output logic        tx_req,
  input  logic [7:0]  tx_data,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        rmii_txen,
  output logic [1:0]  rmii_txdata
);

  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);
  localparam logic [15:0] IFG_L = 16'(IFG_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IFG} state_t;

  state_t      state;
  logic [1:0]  slot;
  logic [15:0] cnt;
  logic [15:0] len;
  logic [7:0]  shreg;
  logic [31:0] crc;
  logic [31:0] crc_upd;

  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // CRC including the dibit going onto the wire this cycle
  always_comb begin
    crc_upd = crc_dibit(crc, shreg[1:0]);
  end

  // The state registers run one cycle ahead of the registered wire outputs:
  // each edge in a byte state emits shreg[1:0] and decides the following byte at slot 3.
  always_ff @(posedge rmii_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      slot        <= 2'd0;
      cnt         <= 16'd0;
      len         <= 16'd0;
      shreg       <= 8'h00;
      crc         <= 32'hFFFFFFFF;
      tx_req      <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      rmii_txen   <= 1'b0;
      rmii_txdata <= 2'b00;
    end else begin
      tx_req  <= 1'b0;
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx_busy     <= 1'b0;
          rmii_txen   <= 1'b0;
          rmii_txdata <= 2'b00;
          if (tx_start) begin
            state <= PRE;
            slot  <= 2'd0;
            cnt   <= 16'd0;
            shreg <= 8'h55;
            crc   <= 32'hFFFFFFFF;
            len   <= (tx_amount > MAX_L) ? MAX_L : tx_amount;
          end
        end
        IFG: begin
          tx_busy     <= 1'b1;
          rmii_txen   <= 1'b0;
          rmii_txdata <= 2'b00;
          if (cnt == IFG_L) begin
            state   <= IDLE;
            tx_done <= 1'b1;
            cnt     <= 16'd0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          tx_busy     <= 1'b1;
          rmii_txen   <= 1'b1;
          rmii_txdata <= shreg[1:0];
          shreg       <= {2'b00, shreg[7:2]};
          slot        <= slot + 2'd1;
          if (state == DATA || state == PAD) crc <= crc_upd;
          // Request the next payload byte so it arrives by slot 3 of the current byte
          if (slot == 2'd1)
            tx_req <= (state == SFD && len != 16'd0) || (state == DATA && (cnt + 16'd1) < len);
          if (slot == 2'd3) begin
            case (state)
              PRE: begin
                if (cnt == 16'd6) begin
                  state <= SFD;
                  cnt   <= 16'd0;
                  shreg <= 8'hD5;
                end else begin
                  cnt   <= cnt + 16'd1;
                  shreg <= 8'h55;
                end
              end
              SFD: begin
                cnt <= 16'd0;
                if (len != 16'd0) begin
                  state <= DATA;
                  shreg <= tx_data;
                end else begin
                  state <= PAD;
                  shreg <= 8'h00;
                end
              end
              DATA: begin
                if ((cnt + 16'd1) < len) begin
                  cnt   <= cnt + 16'd1;
                  shreg <= tx_data;
                end else if (len < MIN_L) begin
                  state <= PAD;
                  cnt   <= len;
                  shreg <= 8'h00;
                end else begin
                  state <= FCS;
                  cnt   <= 16'd0;
                  shreg <= ~crc_upd[7:0];
                  crc   <= {8'h00, ~crc_upd[31:8]};
                end
              end
              PAD: begin
                if ((cnt + 16'd1) < MIN_L) begin
                  cnt   <= cnt + 16'd1;
                  shreg <= 8'h00;
                end else begin
                  state <= FCS;
                  cnt   <= 16'd0;
                  shreg <= ~crc_upd[7:0];
                  crc   <= {8'h00, ~crc_upd[31:8]};
                end
              end
              FCS: begin
                if (cnt == 16'd3) begin
                  state <= IFG;
                  cnt   <= 16'd0;
                end else begin
                  cnt   <= cnt + 16'd1;
                  shreg <= crc[7:0];
                  crc   <= {8'h00, crc[31:8]};
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rmii_frame_tx.sv
// Bench for rmii_frame_tx: table-driven and random frames checked against a byte-level
// frame model, plus busy-start and mid-frame reset sequences.
module tb_rmii_frame_tx;

  localparam int MAX_LEN = 1514;
  localparam int IFG     = 48;

  logic        rmii_clk = 1'b0;
  logic        sys_rst  = 1'b1;
  logic        tx_start0 = 1'b0;
  logic        tx_start9 = 1'b0;
  logic [15:0] tx_amount = 16'd0;
  logic [7:0]  tx_data   = 8'h00;
  logic        req0, busy0, done0, txen0;
  logic [1:0]  txd0;
  logic        req9, busy9, done9, txen9;
  logic [1:0]  txd9;
  logic        sel = 1'b0;
  logic [7:0]  fifo_q[$];
  int          total = 0;
  int          bad   = 0;

  typedef struct {
    bit sel;
    int amount;
    int exp_txen;
    int exp_req;
  } vec_t;

  always #5 rmii_clk = ~rmii_clk;

  rmii_frame_tx dut (
    .rmii_clk(rmii_clk), .sys_rst(sys_rst), .tx_start(tx_start0), .tx_amount(tx_amount),
    .tx_req(req0), .tx_data(tx_data), .tx_busy(busy0), .tx_done(done0),
    .rmii_txen(txen0), .rmii_txdata(txd0)
  );

  rmii_frame_tx #(.MIN_LEN(9)) dut9 (
    .rmii_clk(rmii_clk), .sys_rst(sys_rst), .tx_start(tx_start9), .tx_amount(tx_amount),
    .tx_req(req9), .tx_data(tx_data), .tx_busy(busy9), .tx_done(done9),
    .rmii_txen(txen9), .rmii_txdata(txd9)
  );

  // Upstream FIFO with registered output, serving whichever DUT is selected
  always @(posedge rmii_clk) begin
    if (sel ? req9 : req0) begin
      if (fifo_q.size() > 0) tx_data <= fifo_q.pop_front();
      else tx_data <= 8'h00;
    end
  end

  function automatic logic [31:0] fcs_model(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic check_output(input string name, input longint actual, input longint expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic drive_start(input bit v);
    if (sel) tx_start9 = v;
    else tx_start0 = v;
  endtask

  task automatic apply_stimulus(input bit which, input int amount, input int inject_at,
                                input bit fixed_payload, output int got_txen, output int got_req);
    logic [7:0] pay[$];
    logic [7:0] body[$];
    logic [7:0] wire_b[$];
    logic [1:0] exp_dib[$];
    logic [1:0] got_dib[$];
    logic [31:0] fcs;
    logic [31:0] wire_fcs;
    int l, min_len, blen, budget;
    int busy_cnt, txen_cnt, req_cnt, req_first, last_req, gap_bad, dib_bad, idle_bad;
    int done_cnt, done_at;
    bit seen, ended, first_busy;
    logic s_busy, s_txen, s_req, s_done;
    logic [1:0] s_data;

    sel     = which;
    min_len = which ? 9 : 60;
    l       = (amount > MAX_LEN) ? MAX_LEN : amount;
    blen    = (l < min_len) ? min_len : l;
    for (int i = 0; i < l; i++) pay.push_back(fixed_payload ? 8'(8'h31 + i) : 8'($urandom));
    fifo_q.delete();
    foreach (pay[i]) fifo_q.push_back(pay[i]);
    foreach (pay[i]) body.push_back(pay[i]);
    for (int i = l; i < blen; i++) body.push_back(8'h00);
    fcs = fcs_model(body);
    for (int i = 0; i < 7; i++) wire_b.push_back(8'h55);
    wire_b.push_back(8'hD5);
    foreach (body[i]) wire_b.push_back(body[i]);
    for (int i = 0; i < 4; i++) wire_b.push_back(8'(fcs >> (8 * i)));
    foreach (wire_b[i])
      for (int k = 0; k < 4; k++) exp_dib.push_back(2'((wire_b[i] >> (2 * k)) & 8'h03));

    @(negedge rmii_clk);
    tx_amount = 16'(amount);
    drive_start(1'b1);
    @(negedge rmii_clk);
    drive_start(1'b0);

    budget = 4 * (12 + blen) + IFG + 50;
    busy_cnt = 0; txen_cnt = 0; req_cnt = 0; req_first = -1; last_req = 0; gap_bad = 0;
    dib_bad = 0; idle_bad = 0; done_cnt = 0; done_at = -1;
    seen = 0; ended = 0; first_busy = 0;
    for (int c = 0; c < budget && !ended; c++) begin
      @(negedge rmii_clk);
      s_busy = which ? busy9 : busy0;
      s_txen = which ? txen9 : txen0;
      s_data = which ? txd9  : txd0;
      s_req  = which ? req9  : req0;
      s_done = which ? done9 : done0;
      if (c == 0) first_busy = s_busy;
      if (seen && !s_busy) ended = 1;
      if (s_busy) begin
        seen = 1;
        busy_cnt++;
      end
      if (s_txen) begin
        if (txen_cnt < exp_dib.size() && s_data !== exp_dib[txen_cnt]) dib_bad++;
        got_dib.push_back(s_data);
        txen_cnt++;
      end else if (s_data !== 2'b00) begin
        idle_bad++;
      end
      if (s_req) begin
        if (req_cnt == 0) req_first = txen_cnt - 1;
        else if (c - last_req != 4) gap_bad++;
        last_req = c;
        req_cnt++;
      end
      if (s_done) begin
        done_cnt++;
        done_at = busy_cnt;
      end
      if (inject_at >= 0 && s_txen && txen_cnt == inject_at) begin
        tx_amount = 16'd500;
        drive_start(1'b1);
      end else begin
        drive_start(1'b0);
      end
    end
    drive_start(1'b0);

    check_output("frame_end", longint'(ended), 1);
    check_output("busy_latency", longint'(first_busy), 1);
    check_output("txen_cycles", txen_cnt, 4 * (12 + blen));
    check_output("dibit_errors", dib_bad, 0);
    check_output("idle_txdata", idle_bad, 0);
    check_output("req_count", req_cnt, l);
    check_output("req_spacing", gap_bad, 0);
    if (l > 0) check_output("req_first", req_first, 29);
    check_output("busy_cycles", busy_cnt, 4 * (12 + blen) + IFG);
    check_output("done_count", done_cnt, 1);
    check_output("done_position", done_at, busy_cnt);
    if (fixed_payload && got_dib.size() >= 16) begin
      wire_fcs = 32'h0;
      for (int k = 0; k < 16; k++)
        wire_fcs = wire_fcs | (32'(got_dib[got_dib.size() - 16 + k]) << (2 * k));
      check_output("fcs_123456789", longint'(wire_fcs), longint'(32'hCBF43926));
    end
    got_txen = txen_cnt;
    got_req  = req_cnt;
  endtask

  initial begin
    vec_t vecs[$];
    int got_txen, got_req, n, amt, idle_busy;

    vecs.push_back('{0, 0,    288,  0});
    vecs.push_back('{0, 100,  448,  100});
    vecs.push_back('{0, 20,   288,  20});
    vecs.push_back('{0, 1,    288,  1});
    vecs.push_back('{0, 60,   288,  60});
    vecs.push_back('{0, 61,   292,  61});
    vecs.push_back('{0, 2000, 6104, 1514});
    vecs.push_back('{0, 1514, 6104, 1514});
    vecs.push_back('{1, 5,    84,   5});
    vecs.push_back('{1, 12,   96,   12});

    repeat (4) @(negedge rmii_clk);
    check_output("reset_outputs", longint'({txen0, txd0, req0, busy0, done0}), 0);
    check_output("reset_outputs9", longint'({txen9, txd9, req9, busy9, done9}), 0);
    sys_rst = 1'b0;
    repeat (3) @(negedge rmii_clk);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].sel, vecs[i].amount, -1, 1'b0, got_txen, got_req);
      check_output($sformatf("table%0d_txen", i), got_txen, vecs[i].exp_txen);
      check_output($sformatf("table%0d_req", i), got_req, vecs[i].exp_req);
      repeat (3) @(negedge rmii_clk);
    end

    apply_stimulus(1'b1, 9, -1, 1'b1, got_txen, got_req);
    check_output("crc_txen", got_txen, 84);

    for (int r = 0; r < 6; r++) begin
      amt = (r < 4) ? int'($urandom_range(150)) : int'($urandom_range(30));
      apply_stimulus(r >= 4, amt, -1, 1'b0, got_txen, got_req);
    end

    // A start pulse mid-frame must neither restart nor queue a second frame
    apply_stimulus(1'b0, 30, 100, 1'b0, got_txen, got_req);
    idle_busy = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge rmii_clk);
      if (busy0 || txen0) idle_busy++;
    end
    check_output("no_second_frame", idle_busy, 0);

    // Reset in the middle of a frame
    sel = 1'b0;
    fifo_q.delete();
    for (int i = 0; i < 100; i++) fifo_q.push_back(8'($urandom));
    @(negedge rmii_clk);
    tx_amount = 16'd100;
    tx_start0 = 1'b1;
    @(negedge rmii_clk);
    tx_start0 = 1'b0;
    n = 0;
    for (int c = 0; c < 1000 && n < 150; c++) begin
      @(negedge rmii_clk);
      if (txen0) n++;
    end
    check_output("reset_reach_150", n, 150);
    sys_rst = 1'b1;
    @(negedge rmii_clk);
    check_output("midreset_txen", longint'(txen0), 0);
    check_output("midreset_req", longint'(req0), 0);
    check_output("midreset_busy", longint'(busy0), 0);
    sys_rst = 1'b0;
    idle_busy = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge rmii_clk);
      if (busy0 || txen0) idle_busy++;
    end
    check_output("post_reset_idle", idle_busy, 0);
    apply_stimulus(1'b0, 45, -1, 1'b0, got_txen, got_req);
    check_output("post_reset_txen", got_txen, 288);
    check_output("post_reset_req", got_req, 45);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
